// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Latency is 33 cycles from operand latch to div_done. With DIV_FAST_SPECIAL_EN,
// divide-by-zero and signed overflow finish in 1 cycle.
// Backpressure: none. The pipe stalls on ex_is_div_inst until the div_done pulse.
//   clk, rst        : core clock; synchronous active-high reset
//   ex_is_div_inst  : EX holds a divide (held stable while stalled)
//   ex_flush        : EX instruction killed; abort and return to IDLE
//   div_op          : funct3[1:0] (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   div_src1/2      : dividend / divisor
//   div_done        : one-cycle result-valid pulse (pure state decode)
//   div_result      : registered quotient or remainder
// Optional feature macro: DIV_FAST_SPECIAL_EN (special-case early completion).
module ex_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_is_div_inst,
  input  logic            ex_flush,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] div_src1,
  input  logic [XLEN-1:0] div_src2,
  output logic            div_done,
  output logic [XLEN-1:0] div_result
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [5:0]      LAST_STEP = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            rem_sel_q, rem_sel_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  // Operand conditioning in IDLE
  logic            src1_neg, src2_neg, in_dbz, in_ovf;
  logic [XLEN-1:0] src1_mag, src2_mag;

  assign src1_neg = ~div_op[0] & div_src1[XLEN-1];
  assign src2_neg = ~div_op[0] & div_src2[XLEN-1];
  assign src1_mag = src1_neg ? -div_src1 : div_src1;
  assign src2_mag = src2_neg ? -div_src2 : div_src2;
  assign in_dbz   = (div_src2 == '0);
  assign in_ovf   = ~div_op[0] & (div_src1 == MIN_NEG) & (div_src2 == '1);

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor if it fits, and shift the quotient bit in.
  // The shifted remainder needs XLEN+1 bits; when the subtraction is taken the
  // true difference is below the divisor, so the low XLEN bits are exact.
  logic [XLEN:0]   rem_sh;
  logic            step_ge;
  logic [XLEN-1:0] rem_diff, rem_nxt, quot_nxt;

  assign rem_sh   = {rem_q, quot_q[XLEN-1]};
  assign step_ge  = (rem_sh >= {1'b0, dvsr_q});
  assign rem_diff = rem_sh[XLEN-1:0] - dvsr_q;
  assign rem_nxt  = step_ge ? rem_diff : rem_sh[XLEN-1:0];
  assign quot_nxt = {quot_q[XLEN-2:0], step_ge};

  // Sign restore and special-case fix-up applied on the last step, so the
  // value lands in result_q on the same edge that enters DONE.
  logic [XLEN-1:0] q_fin, r_fin, busy_result;

  always_comb begin
    q_fin = q_neg_q ? -quot_nxt : quot_nxt;
    r_fin = r_neg_q ? -rem_nxt  : rem_nxt;
    if (dbz_q) begin
      q_fin = '1;
      r_fin = src1_q;
    end else if (ovf_q) begin
      q_fin = MIN_NEG;
      r_fin = '0;
    end
    busy_result = rem_sel_q ? r_fin : q_fin;
  end

`ifdef DIV_FAST_SPECIAL_EN
  logic [XLEN-1:0] spec_result;

  always_comb begin
    if (div_op[1]) spec_result = in_dbz ? div_src1 : '0;
    else           spec_result = in_dbz ? '1 : MIN_NEG;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvsr_d    = dvsr_q;
    src1_d    = src1_q;
    result_d  = result_q;
    rem_sel_d = rem_sel_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (ex_is_div_inst && !ex_flush) begin
          rem_sel_d = div_op[1];
          q_neg_d   = src1_neg ^ src2_neg;
          r_neg_d   = src1_neg;
          rem_d     = '0;
          quot_d    = src1_mag;
          dvsr_d    = src2_mag;
          src1_d    = div_src1;
          dbz_d     = in_dbz;
          ovf_d     = in_ovf;
          cnt_d     = '0;
          state_d   = S_BUSY;
`ifdef DIV_FAST_SPECIAL_EN
          if (in_dbz || in_ovf) begin
            result_d = spec_result;
            state_d  = S_DONE;
          end
`endif
        end
      end

      S_BUSY: begin
        if (ex_flush) begin
          // Killed instruction: drop the partial result, keep old div_result.
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          rem_d  = rem_nxt;
          quot_d = quot_nxt;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) begin
            result_d = busy_result;
            cnt_d    = '0;
            state_d  = S_DONE;
          end
        end
      end

      // The pipe advances on this edge; never re-trigger on the retiring
      // instruction, so DONE always falls back to IDLE.
      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      dvsr_q    <= '0;
      src1_q    <= '0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      dvsr_q    <= dvsr_d;
      src1_q    <= src1_d;
      result_q  <= result_d;
      rem_sel_q <= rem_sel_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign div_done   = (state_q == S_DONE);
  assign div_result = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: self-checking bench for ex_div_unit.
// Directed, randomized, back-to-back, flush and mid-divide reset scenarios,
// each compared against a plain-arithmetic RISC-V divide model.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_is_div_inst;
  logic        ex_flush;
  logic [1:0]  div_op;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_done;
  logic [31:0] div_result;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] last_exp;
  bit hold_req = 1'b0;

  localparam int FULL_LAT = 33;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  always #5 clk = ~clk;

  ex_div_unit #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_is_div_inst (ex_is_div_inst),
    .ex_flush       (ex_flush),
    .div_op         (div_op),
    .div_src1       (div_src1),
    .div_src2       (div_src2),
    .div_done       (div_done),
    .div_result     (div_result)
  );

  // Protocol guard: a divide in flight must keep ex_is_div_inst high.
  always @(posedge clk) begin
    if (hold_req && !ex_is_div_inst && !ex_flush && !rst)
      $error("ex_is_div_inst dropped while a divide is in flight");
  end

  // Reference model: RISC-V M-extension divide semantics.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    return op[1] ? a % b : a / b;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return SPECIAL_LAT;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SPECIAL_LAT;
    return FULL_LAT;
  endfunction

  // Issue one divide at the current cycle (T), wait for div_done, return the
  // cycle offset and result; leaves the bench in cycle T+lat+1 with the
  // instruction retired.
  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    div_op = op; div_src1 = a; div_src2 = b;
    ex_is_div_inst = 1'b1; ex_flush = 1'b0;
    lat = -1; res = 'x;
    hold_req = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (div_done) begin
        lat = c;
        res = div_result;
        break;
      end
    end
    hold_req = 1'b0;
    @(posedge clk); #1;
    ex_is_div_inst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ex_is_div_inst = 1'b0; ex_flush = 1'b0;
    div_op = 2'd0; div_src1 = '0; div_src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    if (div_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", div_done);
    else n_pass++;
    n_total++;
    if (div_result !== 32'd0) $display("FAIL reset_result: got %h expected 00000000", div_result);
    else n_pass++;
    n_total++;
    rst = 1'b0;
    @(posedge clk); #1;
    if (div_done !== 1'b0) $display("FAIL post_reset_idle: got %b expected 0", div_done);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_directed;
    logic [1:0]  t_op [11] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2};
    logic [31:0] t_a  [11] = '{32'd20, 32'd20, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd5, 32'd5,
                               32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] t_b  [11] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd1, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] t_e  [11] = '{32'd6, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                               32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    bit          t_sp [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int          lat;
    int          exp_lat;
    logic [31:0] res;
    for (int i = 0; i < 11; i++) begin
      do_div(t_op[i], t_a[i], t_b[i], lat, res);
      exp_lat = t_sp[i] ? SPECIAL_LAT : FULL_LAT;
      if (res !== t_e[i]) $display("FAIL directed_result[%0d]: got %h expected %h", i, res, t_e[i]);
      else n_pass++;
      n_total++;
      if (lat != exp_lat) $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, exp_lat);
      else n_pass++;
      n_total++;
      last_exp = t_e[i];
    end
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      do_div(op, a, b, lat, res);
      if (res !== ref_div(op, a, b))
        $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, ref_div(op, a, b));
      else n_pass++;
      n_total++;
      if (lat != ref_lat(op, a, b))
        $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, ref_lat(op, a, b));
      else n_pass++;
      n_total++;
      if (div_done !== 1'b0) $display("FAIL random_pulse_width[%0d]: got %b expected 0", i, div_done);
      else n_pass++;
      n_total++;
      last_exp = ref_div(op, a, b);
    end
  endtask

  task automatic test_back_to_back;
    int          pulses = 0;
    int          cyc [2] = '{-1, -1};
    logic [31:0] res [2];
    res[0] = 'x; res[1] = 'x;
    div_op = 2'd0; div_src1 = 32'd100; div_src2 = 32'd10;
    ex_is_div_inst = 1'b1; ex_flush = 1'b0;
    for (int c = 1; c <= 75; c++) begin
      @(posedge clk); #1;
      if (div_done) begin
        if (pulses < 2) begin
          cyc[pulses] = c;
          res[pulses] = div_result;
        end
        pulses++;
      end
      if (c == 34) begin div_src1 = 32'd9; div_src2 = 32'd4; end
      if (c == 68) ex_is_div_inst = 1'b0;
    end
    if (pulses != 2) $display("FAIL b2b_pulse_count: got %0d expected 2", pulses);
    else n_pass++;
    n_total++;
    if (cyc[0] != 33) $display("FAIL b2b_first_cycle: got %0d expected 33", cyc[0]);
    else n_pass++;
    n_total++;
    if (cyc[1] != 67) $display("FAIL b2b_second_cycle: got %0d expected 67", cyc[1]);
    else n_pass++;
    n_total++;
    if (res[0] !== 32'd10) $display("FAIL b2b_first_result: got %h expected 0000000a", res[0]);
    else n_pass++;
    n_total++;
    if (res[1] !== 32'd2) $display("FAIL b2b_second_result: got %h expected 00000002", res[1]);
    else n_pass++;
    n_total++;
    last_exp = 32'd2;
  endtask

  task automatic test_flush;
    int          pulses = 0;
    int          first = -1;
    logic [31:0] res = 'x;
    logic [31:0] held = 'x;
    div_op = 2'd0; div_src1 = 32'd1000; div_src2 = 32'd7;
    ex_is_div_inst = 1'b1; ex_flush = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (div_done) begin
        pulses++;
        if (first < 0) begin first = c; res = div_result; end
      end
      if (c == 44) held = div_result;
      if (c == 10) ex_flush = 1'b1;
      if (c == 11) begin ex_flush = 1'b0; ex_is_div_inst = 1'b0; end
      if (c == 12) begin div_src1 = 32'd8; div_src2 = 32'd2; ex_is_div_inst = 1'b1; end
      if (c == 46) ex_is_div_inst = 1'b0;
    end
    if (pulses != 1) $display("FAIL flush_pulse_count: got %0d expected 1", pulses);
    else n_pass++;
    n_total++;
    if (first != 45) $display("FAIL flush_done_cycle: got %0d expected 45", first);
    else n_pass++;
    n_total++;
    if (res !== 32'd4) $display("FAIL flush_next_result: got %h expected 00000004", res);
    else n_pass++;
    n_total++;
    if (held !== last_exp) $display("FAIL flush_result_held: got %h expected %h", held, last_exp);
    else n_pass++;
    n_total++;
    last_exp = 32'd4;
  endtask

  task automatic test_reset_mid;
    int          lat;
    logic [31:0] res;
    div_op = 2'd0; div_src1 = 32'd50; div_src2 = 32'd7;
    ex_is_div_inst = 1'b1; ex_flush = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 5) rst = 1'b1;
    end
    if (div_done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", div_done);
    else n_pass++;
    n_total++;
    if (div_result !== 32'd0) $display("FAIL midreset_result: got %h expected 00000000", div_result);
    else n_pass++;
    n_total++;
    rst = 1'b0; ex_is_div_inst = 1'b0;
    @(posedge clk); #1;
    do_div(2'd0, 32'd9, 32'd3, lat, res);
    if (res !== 32'd3) $display("FAIL midreset_next_result: got %h expected 00000003", res);
    else n_pass++;
    n_total++;
    if (lat != FULL_LAT) $display("FAIL midreset_next_latency: got %0d expected %0d", lat, FULL_LAT);
    else n_pass++;
    n_total++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
